ram_access_ctrl: RTL and testbench

- Memory-side partner of the control unit: consumes MOV/RW/SSE plus address/data, runs the RAM access with programmable wait states, returns MOC.
- Holds a byte-addressed, big-endian internal RAM, so the same block serves both instruction fetch and load/store data.
- Sits directly downstream of the control unit's memory-request outputs (the MAR/MDR path) and feeds MDR/IR via DataOut.

---
 rtl/ram_access_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_ram_access_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ram_access_ctrl.sv
// Wait-state RAM access controller with a byte-addressed, big-endian internal RAM.
// Optional misaligned-access trap is enabled by defining RAM_ALIGN_CHECK_EN.
module ram_access_ctrl #(
  parameter int DEPTH_BYTES = 512,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MOV,
  input  logic              RW,
  input  logic [1:0]        SSE,
  input  logic              SIGNED,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MOC,
  output logic              ERR
);

  // state  | meaning
  // IDLE   | waiting for MOV, request fields captured on MOV
  // WAIT   | counting down wait states, MOV low aborts
  // DONE   | access performed, MOC held until MOV drops
  localparam int         IDX_W   = $clog2(DEPTH_BYTES);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             rw_q, rw_d;
  logic [1:0]       sse_q, sse_d;
  logic             sgn_q, sgn_d;
  logic             moc_q, moc_d;
  logic             err_q, err_d;
  logic [31:0]      dout_q, dout_d;

  logic [7:0]       mem [DEPTH_BYTES];

  logic             capture, go_done, acc_err, do_wr;
  logic [IDX_W-1:0] acc_addr, a0, a1, a2, a3;
  logic [31:0]      acc_wdata, rd_data;
  logic             acc_rw, acc_sgn, misalign;
  logic [1:0]       acc_sse;
  logic [7:0]       b0, b1, b2, b3;
  logic             unused_addr;

  assign unused_addr = ^Address[ADDR_W-1:IDX_W];

  assign capture = (state_q == S_IDLE) && MOV;

  // With zero wait states the access happens on the capture edge, so use the live inputs.
  assign acc_addr  = capture ? Address[IDX_W-1:0] : addr_q;
  assign acc_wdata = capture ? DataIn : wdata_q;
  assign acc_rw    = capture ? RW     : rw_q;
  assign acc_sse   = capture ? SSE    : sse_q;
  assign acc_sgn   = capture ? SIGNED : sgn_q;

  assign misalign = ((acc_sse == 2'b01) && acc_addr[0]) ||
                    (acc_sse[1] && (acc_addr[1:0] != 2'b00));

`ifdef RAM_ALIGN_CHECK_EN
  assign acc_err = misalign;
  assign a0      = acc_addr;
`else
  assign acc_err = 1'b0;
  always_comb begin
    a0 = acc_addr;
    if (acc_sse == 2'b01) a0[0] = 1'b0;
    else if (acc_sse[1])  a0[1:0] = 2'b00;
  end
`endif

  assign a1 = a0 + IDX_W'(1);
  assign a2 = a0 + IDX_W'(2);
  assign a3 = a0 + IDX_W'(3);

  assign go_done = (capture && (WAIT_CYCLES == 0)) ||
                   ((state_q == S_WAIT) && MOV && (cnt_q == 4'd1));
  assign do_wr   = go_done && !acc_rw && !acc_err;

  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  always_comb begin
    rd_data = {b0, b1, b2, b3};
    case (acc_sse)
      2'b00:   rd_data = {{24{acc_sgn & b0[7]}}, b0};
      2'b01:   rd_data = {{16{acc_sgn & b0[7]}}, b0, b1};
      default: rd_data = {b0, b1, b2, b3};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    sse_d   = sse_q;
    sgn_d   = sgn_q;
    moc_d   = moc_q;
    err_d   = err_q;
    dout_d  = dout_q;
    case (state_q)
      S_IDLE: begin
        if (MOV) begin
          addr_d  = Address[IDX_W-1:0];
          wdata_d = DataIn;
          rw_d    = RW;
          sse_d   = SSE;
          sgn_d   = SIGNED;
          cnt_d   = WAIT_LD;
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
        end
      end
      S_WAIT: begin
        if (!MOV) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!MOV) begin
          state_d = S_IDLE;
          moc_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (go_done) begin
      moc_d = 1'b1;
      err_d = acc_err;
      if (acc_rw && !acc_err) dout_d = rd_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rw_q    <= 1'b0;
      sse_q   <= 2'b00;
      sgn_q   <= 1'b0;
      moc_q   <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      sse_q   <= sse_d;
      sgn_q   <= sgn_d;
      moc_q   <= moc_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  // RAM has no reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (reset && do_wr) begin
      case (acc_sse)
        2'b00: mem[a0] <= acc_wdata[7:0];
        2'b01: begin
          mem[a0] <= acc_wdata[15:8];
          mem[a1] <= acc_wdata[7:0];
        end
        default: begin
          mem[a0] <= acc_wdata[31:24];
          mem[a1] <= acc_wdata[23:16];
          mem[a2] <= acc_wdata[15:8];
          mem[a3] <= acc_wdata[7:0];
        end
      endcase
    end
  end

  assign DataOut = dout_q;
  assign MOC     = moc_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl: byte-array RAM model with a per-cycle output compare.
`timescale 1ns/1ps
module tb_ram_access_ctrl;
  localparam int DEPTH = 512;
  localparam int W     = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MOV = 1'b0, RW = 1'b0, SIGNED = 1'b0;
  logic [1:0]  SSE = 2'b00;
  logic [31:0] Address = 32'd0, DataIn = 32'd0;
  wire  [31:0] DataOut;
  wire         MOC, ERR;

  ram_access_ctrl #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(W), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .MOV(MOV), .RW(RW), .SSE(SSE), .SIGNED(SIGNED),
    .Address(Address), .DataIn(DataIn), .DataOut(DataOut), .MOC(MOC), .ERR(ERR)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_bad = 0;
  logic [7:0]  mm [DEPTH];
  logic        exp_moc = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_dout = 32'd0;
  bit          chk_en = 1'b0;
  logic        seen_moc, seen_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("moc", {31'b0, MOC}, {31'b0, exp_moc});
      chk("err", {31'b0, ERR}, {31'b0, exp_err});
      chk("dataout", DataOut, exp_dout);
    end
  end

  // Whole-access model: index, size, alignment and extension from plain arithmetic.
  task automatic model_access(input logic rw, input logic [1:0] sse, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] data);
    int a, sz;
    logic [31:0] v;
    a  = int'(addr % 32'(DEPTH));
    sz = (sse == 2'b00) ? 1 : (sse == 2'b01) ? 2 : 4;
`ifdef RAM_ALIGN_CHECK_EN
    if ((a % sz) != 0) begin
      exp_err = 1'b1;
      return;
    end
`else
    a = a - (a % sz);
`endif
    exp_err = 1'b0;
    if (!rw) begin
      for (int b = 0; b < sz; b++) mm[a + b] = 8'(data >> (8 * (sz - 1 - b)));
    end else begin
      v = 32'd0;
      for (int b = 0; b < sz; b++) v = (v << 8) | {24'd0, mm[a + b]};
      if (sgn && sz < 4 && v[8 * sz - 1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
      exp_dout = v;
    end
  endtask

  task automatic scramble();
    Address = $urandom;
    DataIn  = $urandom;
    RW      = 1'($urandom);
    SSE     = 2'($urandom);
    SIGNED  = 1'($urandom);
  endtask

  // abort_k>0 drops MOV so it is sampled low on the k-th edge after capture.
  task automatic op(input logic rw, input logic [1:0] sse, input logic sgn,
                    input logic [31:0] addr, input logic [31:0] data,
                    input int abort_k, input int hold);
    @(negedge clk);
    MOV = 1'b1; RW = rw; SSE = sse; SIGNED = sgn; Address = addr; DataIn = data;
    @(posedge clk);
    if (W == 0) begin
      model_access(rw, sse, sgn, addr, data);
      exp_moc = 1'b1;
    end
    for (int c = 1; c <= W; c++) begin
      @(negedge clk);
      scramble();
      if (c == abort_k) MOV = 1'b0;
      @(posedge clk);
      if (c == abort_k) return;
      if (c == W) begin
        model_access(rw, sse, sgn, addr, data);
        exp_moc = 1'b1;
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      scramble();
      @(posedge clk);
    end
    @(negedge clk);
    seen_moc = MOC;
    seen_err = ERR;
    MOV = 1'b0;
    scramble();
    @(posedge clk);
    exp_moc = 1'b0;
    exp_err = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_moc", {31'b0, MOC}, 32'd0);
    chk("rst_err", {31'b0, ERR}, 32'd0);
    chk("rst_dout", DataOut, 32'd0);
    reset  = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < DEPTH; i += 4) op(1'b0, 2'b10, 1'b0, 32'(i), $urandom, 0, 0);

    op(1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, 1);
    chk("wr_moc_held", {31'b0, seen_moc}, 32'd1);
    op(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 0, 0);
    chk("rd_word", DataOut, 32'hDEADBEEF);
    op(1'b1, 2'b00, 1'b1, 32'h11, 32'h0, 0, 0);
    chk("rd_byte_s", DataOut, 32'hFFFFFFAD);
    op(1'b1, 2'b00, 1'b0, 32'h11, 32'h0, 0, 2);
    chk("rd_byte_u", DataOut, 32'h000000AD);
    op(1'b0, 2'b01, 1'b0, 32'h12, 32'h1234, 0, 0);
    op(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 0, 0);
    chk("rd_word2", DataOut, 32'hDEAD1234);
    op(1'b1, 2'b01, 1'b1, 32'h12, 32'h0, 0, 0);
    chk("rd_half_s", DataOut, 32'h00001234);

    op(1'b0, 2'b00, 1'b0, 32'h20, 32'hA5, 0, 0);
    op(1'b0, 2'b00, 1'b0, 32'h20, 32'h55, 1, 0);
    op(1'b1, 2'b00, 1'b0, 32'h20, 32'h0, 0, 0);
    chk("abort_keep", DataOut, 32'h000000A5);

    op(1'b0, 2'b00, 1'b0, 32'h30, 32'h3C, 0, 0);
    @(negedge clk);
    MOV = 1'b1; RW = 1'b0; SSE = 2'b00; SIGNED = 1'b0; Address = 32'h30; DataIn = 32'h77;
    @(posedge clk);
    #2;
    reset = 1'b0;
    exp_moc = 1'b0; exp_err = 1'b0; exp_dout = 32'd0;
    #1;
    chk("async_moc", {31'b0, MOC}, 32'd0);
    chk("async_dout", DataOut, 32'd0);
    MOV = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    op(1'b1, 2'b00, 1'b0, 32'h30, 32'h0, 0, 0);
    chk("rst_keep", DataOut, 32'h0000003C);

    op(1'b0, 2'b10, 1'b0, 32'h0000_03FC, 32'h01020304, 0, 0);
    op(1'b1, 2'b10, 1'b0, 32'h0000_01FC, 32'h0, 0, 0);
    chk("last_word", DataOut, 32'h01020304);

    op(1'b0, 2'b10, 1'b0, 32'h13, 32'hCAFEF00D, 0, 0);
`ifdef RAM_ALIGN_CHECK_EN
    chk("mis_err", {31'b0, seen_err}, 32'd1);
    chk("mis_moc", {31'b0, seen_moc}, 32'd1);
    op(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 0, 0);
    chk("mis_keep", DataOut, 32'hDEAD1234);
`else
    chk("mis_err", {31'b0, seen_err}, 32'd0);
    chk("mis_moc", {31'b0, seen_moc}, 32'd1);
    op(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 0, 0);
    chk("mis_land", DataOut, 32'hCAFEF00D);
`endif

    repeat (300) begin
      int k;
      k = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, W)) : 0;
      op(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, k,
         int'($urandom_range(0, 2)));
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
